// File: rtl/rr_arb_2to1.sv
// ----------------------------------------------------------------------------
// rr_arb_2to1
//   Upstream/select stage for the 2:1 mux datapath. Two valid/ready requesters
//   are arbitrated round-robin. The winning word is registered into a single
//   output slot. sel_o is the matching select for the downstream mux
//   (0 = a, 1 = b). Each input also has a saturating counter of accepted words.
//
// Parameters
//   WIDTH  data width of the a/b/y words
//   CNT_W  width of each saturating grant counter
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   a_valid_i  requester A has a word        a_data_i  requester A word
//   a_ready_o  A word accepted this cycle
//   b_valid_i  requester B has a word        b_data_i  requester B word
//   b_ready_o  B word accepted this cycle
//   y_valid_o  output slot holds a word      y_data_o  registered winning word
//   y_ready_i  consumer takes y_data_o this cycle
//   sel_o      source of y_data_o (0 = a, 1 = b)
//   a_cnt_o    accepted-A count, saturating
//   b_cnt_o    accepted-B count, saturating
// ----------------------------------------------------------------------------
module rr_arb_2to1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid_i,
    input  logic [WIDTH-1:0] a_data_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             b_ready_o,
    output logic             y_valid_o,
    output logic [WIDTH-1:0] y_data_o,
    input  logic             y_ready_i,
    output logic             sel_o,
    output logic [CNT_W-1:0] a_cnt_o,
    output logic [CNT_W-1:0] b_cnt_o
);

    // The state encoding is the output-valid flag itself.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last;     // 1: B had the last grant, so A wins the next tie
    logic [WIDTH-1:0] r_data;
    logic             r_sel;

    logic             w_load;
    logic             w_any;
    logic             w_grant_a;
    logic             w_grant_b;
    logic [1:0]       w_acc;      // [0] = A accepted, [1] = B accepted

    // The slot can take a new word when it is empty or being drained this cycle.
    assign w_load    = (r_state == ST_EMPTY) | y_ready_i;
    assign w_any     = a_valid_i | b_valid_i;
    assign w_grant_b = b_valid_i & (~a_valid_i | ~r_last);
    assign w_grant_a = a_valid_i & ~w_grant_b;

    // Readys are forced low while reset is asserted so nothing is accepted
    // in a cycle whose state update is discarded.
    assign a_ready_o = ~reset & w_load & w_grant_a;
    assign b_ready_o = ~reset & w_load & w_grant_b;
    assign w_acc     = {b_ready_o, a_ready_o};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_load) begin
            if (w_any) begin
                r_state <= ST_FULL;
                r_data  <= w_grant_b ? b_data_i : a_data_i;
                r_sel   <= w_grant_b;
                r_last  <= w_grant_b;
            end else begin
                // Data and select are left as-is; they are don't-care while empty.
                r_state <= ST_EMPTY;
            end
        end
    end

    // One saturating counter per requester.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_acc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign y_valid_o = (r_state == ST_FULL);
    assign y_data_o  = r_data;
    assign sel_o     = r_sel;
    assign a_cnt_o   = g_cnt[0].r_cnt;
    assign b_cnt_o   = g_cnt[1].r_cnt;

endmodule
